// File: rtl/sdram_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_arbit_if
//   Bundles everything the SDRAM arbiter exchanges with its four requesters
//   (init, auto-refresh, write, read) and with the SDRAM pad ring.
//
//   Requester side : init_end/init_cmd/init_addr,
//                    x_req / x_en / flag_x_end / x_cmd / x_addr for
//                    x in {aref, wr, rd}, plus wr_data.
//   SDRAM side     : sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
//                    sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe.
//
//   modport master : the arbiter's view (it owns the SDRAM pins and the grants).
//   modport slave  : the requesters'/pad view (mirror image of master).
// ---------------------------------------------------------------------------
interface sdram_arbit_if;
    // Power-up init requester
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    // Auto-refresh requester
    logic        aref_req;
    logic        aref_en;
    logic        flag_aref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    // Write requester
    logic        wr_req;
    logic        wr_en;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    // Read requester
    logic        rd_req;
    logic        rd_en;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    // SDRAM pins
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    modport master (
        input  init_end, init_cmd, init_addr,
        input  aref_req, flag_aref_end, aref_cmd, aref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe
    );

    modport slave (
        output init_end, init_cmd, init_addr,
        output aref_req, flag_aref_end, aref_cmd, aref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data,
        output rd_req, flag_rd_end, rd_cmd, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
//   Central arbiter / command multiplexer of the SDRAM controller. Owns the
//   SDRAM command, address and write-data pins and hands them to one of four
//   requesters at a time: power-up init first, then auto-refresh > write >
//   read with fixed priority and no preemption.
//
//   Ports:
//     clk   : system clock, rising edge.
//     rst_n : asynchronous active-low reset.
//     bus   : sdram_arbit_if.master (requester handshakes + SDRAM pins).
//
//   Parameters:
//     BANK      : constant bank address on sdram_ba.
//     IDLE_ADDR : address driven when nobody owns the bus (A10 high).
// ---------------------------------------------------------------------------
module sdram_arbit #(
    parameter logic [1:0]  BANK      = 2'b00,
    parameter logic [12:0] IDLE_ADDR = 13'b0_0100_0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    sdram_arbit_if.master   bus
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [4:0] {
        ARB_INIT  = 5'b0_0001,
        ARB_IDLE  = 5'b0_0010,
        ARB_AREF  = 5'b0_0100,
        ARB_WRITE = 5'b0_1000,
        ARB_READ  = 5'b1_0000
    } arb_state_t;

    arb_state_t  r_state_c;
    arb_state_t  w_state_n;

    logic [3:0]  w_cmd;
    logic [12:0] w_addr;

    logic [3:0]  r_cmd;
    logic [12:0] r_addr;
    logic [15:0] r_dq_out;
    logic        r_dq_oe;
    logic        r_aref_en;
    logic        r_wr_en;
    logic        r_rd_en;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_c <= ARB_INIT;
        end else begin
            r_state_c <= w_state_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Owners only ever return to IDLE, so a request that
    // arrives together with an end flag always sees one IDLE cycle first.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state_c;
        case (r_state_c)
            ARB_INIT: begin
                if (bus.init_end) w_state_n = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (bus.aref_req)      w_state_n = ARB_AREF;
                else if (bus.wr_req)   w_state_n = ARB_WRITE;
                else if (bus.rd_req)   w_state_n = ARB_READ;
            end
            ARB_AREF: begin
                if (bus.flag_aref_end) w_state_n = ARB_IDLE;
            end
            ARB_WRITE: begin
                if (bus.flag_wr_end)   w_state_n = ARB_IDLE;
            end
            ARB_READ: begin
                if (bus.flag_rd_end)   w_state_n = ARB_IDLE;
            end
            default: w_state_n = ARB_INIT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Command / address select from the current owner. Registered below, so
    // every requester sees the same one-cycle latency to the pins.
    // -----------------------------------------------------------------------
    always_comb begin
        w_cmd  = CMD_NOP;
        w_addr = IDLE_ADDR;
        case (r_state_c)
            ARB_INIT: begin
                w_cmd  = bus.init_cmd;
                w_addr = bus.init_addr;
            end
            ARB_AREF: begin
                w_cmd  = bus.aref_cmd;
                w_addr = bus.aref_addr;
            end
            ARB_WRITE: begin
                w_cmd  = bus.wr_cmd;
                w_addr = bus.wr_addr;
            end
            ARB_READ: begin
                w_cmd  = bus.rd_cmd;
                w_addr = bus.rd_addr;
            end
            default: begin
                w_cmd  = CMD_NOP;
                w_addr = IDLE_ADDR;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register stage: pins, write data, pad enable and grant pulses.
    // A grant fires only on the IDLE -> owner transition, so it is high
    // during exactly the first cycle the new owner holds the bus.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= CMD_NOP;
            r_addr    <= IDLE_ADDR;
            r_dq_out  <= 16'h0000;
            r_dq_oe   <= 1'b0;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_cmd     <= w_cmd;
            r_addr    <= w_addr;
            r_dq_out  <= bus.wr_data;
            // Aligned with r_cmd so the pad drives exactly while write cmds are on the pins
            r_dq_oe   <= (r_state_c == ARB_WRITE);
            r_aref_en <= (r_state_c == ARB_IDLE) && (w_state_n == ARB_AREF);
            r_wr_en   <= (r_state_c == ARB_IDLE) && (w_state_n == ARB_WRITE);
            r_rd_en   <= (r_state_c == ARB_IDLE) && (w_state_n == ARB_READ);
        end
    end

    assign bus.sdram_cs_n   = r_cmd[3];
    assign bus.sdram_ras_n  = r_cmd[2];
    assign bus.sdram_cas_n  = r_cmd[1];
    assign bus.sdram_we_n   = r_cmd[0];
    assign bus.sdram_addr   = r_addr;
    assign bus.sdram_ba     = BANK;
    assign bus.sdram_dq_out = r_dq_out;
    assign bus.sdram_dq_oe  = r_dq_oe;
    assign bus.aref_en      = r_aref_en;
    assign bus.wr_en        = r_wr_en;
    assign bus.rd_en        = r_rd_en;

endmodule
